// File: rtl/fisc_alu_pkg.sv
// ==== fisc_alu_pkg: opcodes, flag bundle and FSM states for the FISC ALU ====
// ==== Rev 1.0                                                            ====
`default_nettype none

package fisc_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_ORR  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_NOR  = 4'b1100,
    OP_MUL  = 4'b1000,
    OP_DIV  = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/fisc_alu_muldiv.sv
// ==== fisc_alu_muldiv: one-bit-per-cycle shift-add multiply / restoring divide ====
// ==== (divide present only with FISC_ALU_DIV_EN). Rev 1.0                      ====
`default_nettype none

module fisc_alu_muldiv #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             dbz_o
);

  localparam int c_CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   w_sum;
  logic             w_div_start;
  logic             w_dbz;

  // {hi,lo} is the product register for MUL and {remainder,quotient} for DIV.
  assign w_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);

`ifdef FISC_ALU_DIV_EN
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift     = {hi_q, lo_q[WIDTH-1]};
  assign w_ge        = (w_shift >= {1'b0, m_q});
  assign w_diff      = w_shift[WIDTH-1:0] - m_q;
  assign w_div_start = op_i;
  assign w_dbz       = div_q && (m_q == '0);
`else
  logic w_unused_op;
  assign w_unused_op = op_i;
  assign w_div_start = 1'b0;
  assign w_dbz       = 1'b0;
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    m_d    = m_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = c_CW'(WIDTH);
      div_d  = w_div_start;
      hi_d   = '0;
      m_d    = w_div_start ? b_i : a_i;
      lo_d   = w_div_start ? a_i : b_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - c_CW'(1);
        hi_d  = w_sum[WIDTH:1];
        lo_d  = {w_sum[0], lo_q[WIDTH-1:1]};
`ifdef FISC_ALU_DIV_EN
        if (div_q) begin
          hi_d = w_ge ? w_diff : w_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], w_ge};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      m_q    <= m_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = lo_q;
  assign ovf_o    = !div_q && (hi_q != '0);
  assign dbz_o    = w_dbz;

endmodule

`default_nettype wire

// File: rtl/fisc_alu_seq.sv
// ==== fisc_alu_seq: registered, valid/ready execute-stage ALU with N/Z/V/C flags; ====
// ==== FISC_ALU_DIV_EN enables the unsigned divide on code 1001. Rev 1.0          ====
`default_nettype none

module fisc_alu_seq
  import fisc_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int F_SZ  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [F_SZ-1:0]  f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c,
  output logic             err
);

  alu_state_e       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  alu_flags_t       flags_q;
  logic             err_q;

  logic [WIDTH-1:0] w_res;
  logic             w_v, w_c, w_err, w_long, w_div;
  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_accept;
  logic             w_md_done, w_md_ovf, w_md_dbz;
  logic [WIDTH-1:0] w_md_result;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_add = {1'b0, opA} + {1'b0, opB};
  assign w_sub = opA - opB;

  always_comb begin
    w_res  = '0;
    w_v    = 1'b0;
    w_c    = 1'b0;
    w_err  = 1'b0;
    w_long = 1'b0;
    w_div  = 1'b0;
    case (f)
      F_SZ'(OP_AND):  w_res = opA & opB;
      F_SZ'(OP_ORR):  w_res = opA | opB;
      F_SZ'(OP_NOR):  w_res = ~(opA | opB);
      F_SZ'(OP_SLTU): w_res[0] = (opA < opB);
      F_SZ'(OP_ADD): begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (opA[WIDTH-1] == opB[WIDTH-1]) && (w_res[WIDTH-1] != opA[WIDTH-1]);
      end
      F_SZ'(OP_SUB): begin
        w_res = w_sub;
        w_c   = (opA >= opB);
        w_v   = (opA[WIDTH-1] != opB[WIDTH-1]) && (w_res[WIDTH-1] != opA[WIDTH-1]);
      end
      F_SZ'(OP_MUL):  w_long = 1'b1;
`ifdef FISC_ALU_DIV_EN
      F_SZ'(OP_DIV): begin
        w_long = 1'b1;
        w_div  = 1'b1;
      end
`endif
      default:        w_err = 1'b1;
    endcase
  end

  fisc_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (w_accept && w_long),
    .op_i     (w_div),
    .a_i      (opA),
    .b_i      (opB),
    .done_o   (w_md_done),
    .result_o (w_md_result),
    .ovf_o    (w_md_ovf),
    .dbz_o    (w_md_dbz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept && w_long) begin
            state_q     <= BUSY;
            out_valid_q <= 1'b0;
          end else if (w_accept) begin
            out_valid_q <= 1'b1;
            y_q         <= w_res;
            flags_q     <= '{n: w_res[WIDTH-1], z: (w_res == '0), v: w_v, c: w_c};
            err_q       <= w_err;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (w_md_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            y_q         <= w_md_result;
            flags_q     <= '{n: w_md_result[WIDTH-1], z: (w_md_result == '0),
                             v: (w_md_ovf || w_md_dbz), c: 1'b0};
            err_q       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_v    = flags_q.v;
  assign flag_c    = flags_q.c;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fisc_alu_seq.sv
// ==== tb_fisc_alu_seq: directed vectors with a result scoreboard for fisc_alu_seq ====
// ==== Rev 1.0                                                                     ====
`default_nettype none

module tb_fisc_alu_seq;

  localparam int W = 64;
  localparam logic [3:0] c_AND = 4'b0000, c_ORR = 4'b0001, c_ADD = 4'b0010, c_SUB = 4'b0110;
  localparam logic [3:0] c_SLTU = 4'b0111, c_NOR = 4'b1100, c_MUL = 4'b1000, c_DIV = 4'b1001;
  localparam logic [3:0] c_BAD = 4'b0011;
  localparam logic [W-1:0] c_ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [3:0]   f = '0;
  logic         in_ready, out_valid, flag_n, flag_z, flag_v, flag_c, err;
  logic [W-1:0] y;

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   nzvc;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   id_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   op_id = 0;

  fisc_alu_seq #(.WIDTH(W), .F_SZ(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_c    (flag_c),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   id;
    if (reset_n && out_valid && out_ready) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_result: got y=%h with nothing expected", y);
      end else begin
        e  = sb_q.pop_front();
        id = id_q.pop_front();
        if ({y, flag_n, flag_z, flag_v, flag_c, err} !== e) begin
          tests_failed++;
          $display("FAIL result#%0d: got y=%h nzvc=%b err=%b, expected y=%h nzvc=%b err=%b",
                   id, y, {flag_n, flag_z, flag_v, flag_c}, err, e.y, e.nzvc, e.err);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] fc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ey, input logic [3:0] enzvc, input logic eerr,
                       input bit push, output int waits);
    exp_t e;
    in_valid = 1'b1;
    f        = fc;
    opA      = a;
    opB      = b;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", waits);
    end else if (push) begin
      e.y = ey; e.nzvc = enzvc; e.err = eerr;
      sb_q.push_back(e);
      id_q.push_back(op_id);
    end
    op_id++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0 || out_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin
    int w, n, bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags_err", {flag_n, flag_z, flag_v, flag_c, err}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    issue(c_ADD, c_ONES, 64'd1, 64'd0, 4'b0101, 1'b0, 1, w);
    check("add_latency", out_valid, 1);
    issue(c_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010, 1'b0, 1, w);
    issue(c_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1, w);
    issue(c_SUB, 64'd7, 64'd5, 64'd2, 4'b0001, 1'b0, 1, w);
    issue(c_SLTU, 64'd5, 64'd7, 64'd1, 4'b0000, 1'b0, 1, w);
    issue(c_SLTU, 64'd7, 64'd5, 64'd0, 4'b0100, 1'b0, 1, w);
    issue(c_NOR, 64'd0, 64'd0, c_ONES, 4'b1000, 1'b0, 1, w);
    issue(c_BAD, 64'd9, 64'd9, 64'd0, 4'b0100, 1'b1, 1, w);

    issue(c_MUL, 64'd3, 64'd5, 64'd15, 4'b0000, 1'b0, 1, w);
    n = 0;
    bad = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check("mul_latency", n, 65);
    check("mul_in_ready_low", bad, 0);
    issue(c_MUL, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 4'b0110, 1'b0, 1, w);
    issue(c_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4'b1000, 1'b0, 1, w);

    drain();
    out_ready = 1'b0;
    issue(c_ORR, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 1'b0, 1, w);
    for (int i = 0; i < 10; i++) begin
      check("hold_y", y, 64'hFF);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(c_AND, 64'hFF, 64'h0F, 64'h0F, 4'b0000, 1'b0, 1, w);
    check("b2b_accept_wait", w, 0);
    check("b2b_valid", out_valid, 1);

    drain();
    issue(c_MUL, 64'd3, 64'd5, 64'd0, 4'b0000, 1'b0, 0, w);
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_y", y, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("abort_no_result", n, 0);
    issue(c_NOR, 64'd0, 64'd0, c_ONES, 4'b1000, 1'b0, 1, w);

`ifdef FISC_ALU_DIV_EN
    issue(c_DIV, 64'd100, 64'd7, 64'd14, 4'b0000, 1'b0, 1, w);
    issue(c_DIV, 64'd12345, 64'd0, c_ONES, 4'b1010, 1'b0, 1, w);
`else
    issue(c_DIV, 64'd100, 64'd7, 64'd0, 4'b0100, 1'b1, 1, w);
`endif

    drain();
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
